st_sample_source: RTL and testbench

Avalon-ST sample transmitter: buffers 16-bit samples written by a local producer in a small FIFO and streams them out on an Avalon-ST source port (readyLatency 0) into the moving-average sink. It is the sending end of the same ASI/ASO stream the averager consumes. It flags stream discontinuities (FIFO starvation) on the beat that follows a gap. It also reports overflow and underflow through sticky status bits.

---
 rtl/st_sample_source.sv | 116 +++++++++++
 tb/tb_st_sample_source.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/st_sample_source.sv
// Avalon-ST sample source: a small FIFO of producer samples feeding a registered
// readyLatency-0 output beat, with starvation marking and sticky overflow/underflow flags.
module st_sample_source #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       wr_full,
    output logic [$clog2(DEPTH):0]     level,
    input  logic                       enable,
    input  logic                       clr_flags,
    output logic                       wr_overflow,
    output logic                       underflow,
    input  logic                       aso_ready,
    output logic                       aso_valid,
    output logic [DATA_WIDTH-1:0]      aso_data,
    output logic                       aso_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        STARVED
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         count;
    state_t                state;

    logic fifo_empty;
    logic fifo_full;
    logic reg_free;
    logic load;
    logic push;
    logic drop;
    logic starve;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == LW'(DEPTH));
    // The output register can take a new beat if it is empty or its beat leaves this edge.
    assign reg_free   = !aso_valid || aso_ready;
    assign load       = enable && !fifo_empty && reg_free;
    // A full FIFO still accepts a write when the head is popped on the same edge.
    assign push       = wr_en && (!fifo_full || load);
    assign drop       = wr_en && !push;
    assign starve     = enable && reg_free && fifo_empty && (state == STREAM);

    assign wr_full = fifo_full;
    assign level   = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            // NOTE: the default arm keeps count explicitly so the case is complete for every input pattern.
            case ({push, load})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            aso_valid <= 1'b0;
            aso_data  <= '0;
            aso_error <= 1'b0;
        end else begin
            if (load) begin
                aso_valid <= 1'b1;
                aso_data  <= mem[rd_ptr];
                aso_error <= (state == STARVED);
            end else if (aso_valid && aso_ready) begin
                aso_valid <= 1'b0;
            end

            if (!enable && reg_free)
                state <= IDLE;
            else if (load)
                state <= STREAM;
            else if (starve)
                state <= STARVED;
        end
    end

    // Set events take priority over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_overflow <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wr_overflow <= drop   || (wr_overflow && !clr_flags);
            underflow   <= starve || (underflow && !clr_flags);
        end
    end

endmodule

// File: tb/tb_st_sample_source.sv
// Bench for st_sample_source: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_st_sample_source;

    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_full;
    logic [4:0]    level;
    logic          enable = 1'b0;
    logic          clr_flags = 1'b0;
    logic          wr_overflow;
    logic          underflow;
    logic          aso_ready = 1'b0;
    logic          aso_valid;
    logic [DW-1:0] aso_data;
    logic          aso_error;

    int n_checks = 0;
    int n_err    = 0;

    st_sample_source #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .level      (level),
        .enable     (enable),
        .clr_flags  (clr_flags),
        .wr_overflow(wr_overflow),
        .underflow  (underflow),
        .aso_ready  (aso_ready),
        .aso_valid  (aso_valid),
        .aso_data   (aso_data),
        .aso_error  (aso_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: a sample queue, the pending beat, and whether the stream
    // has run dry since the last delivered beat.
    logic [DW-1:0] q[$];
    bit            m_valid, m_err, m_ovf, m_unf, m_active, m_gap;
    logic [DW-1:0] m_data;
    bit            f_free, f_pop, f_acc, f_ovf_set, f_unf_set;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_valid = 0; m_data = '0; m_err = 0;
            m_ovf = 0; m_unf = 0; m_active = 0; m_gap = 0;
        end else begin
            f_free    = !m_valid || aso_ready;
            f_pop     = enable && (q.size() != 0) && f_free;
            f_acc     = wr_en && ((q.size() < DEPTH) || f_pop);
            f_ovf_set = wr_en && !f_acc;
            f_unf_set = 0;
            if (f_pop) begin
                m_valid = 1;
                m_data  = q.pop_front();
                m_err   = m_gap;
            end else if (f_free) begin
                m_valid = 0;
            end
            if (!enable && f_free) begin
                m_active = 0;
                m_gap    = 0;
            end else if (f_pop) begin
                m_active = 1;
                m_gap    = 0;
            end else if (enable && f_free && q.size() == 0 && m_active && !m_gap) begin
                m_gap     = 1;
                f_unf_set = 1;
            end
            if (f_acc) q.push_back(wr_data);
            m_ovf = f_ovf_set || (m_ovf && !clr_flags);
            m_unf = f_unf_set || (m_unf && !clr_flags);
        end
    end

    always @(negedge clk) begin
        check("m_valid", aso_valid, m_valid);
        check("m_level", level, q.size());
        check("m_full", wr_full, q.size() == DEPTH);
        check("m_ovf", wr_overflow, m_ovf);
        check("m_unf", underflow, m_unf);
        if (m_valid) begin
            check("m_data", aso_data, m_data);
            check("m_err", aso_error, m_err);
        end
    end

    logic [DW-1:0] rx[$];
    always @(posedge clk) begin
        if (!reset && aso_valid && aso_ready) rx.push_back(aso_data);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        #1 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", aso_valid, 0);
        check("rst_data", aso_data, 0);
        check("rst_error", aso_error, 0);
        check("rst_level", level, 0);
        check("rst_full", wr_full, 0);
        check("rst_ovf", wr_overflow, 0);
        check("rst_unf", underflow, 0);

        // Basic stream
        enable = 1; aso_ready = 1; tick();
        wr_en = 1; wr_data = 1; tick();
        check("basic_latency", aso_valid, 0);
        wr_data = 2; tick();
        check("basic_v1", aso_valid, 1);
        check("basic_d1", aso_data, 1);
        wr_data = 3; tick();
        check("basic_d2", aso_data, 2);
        wr_en = 0; tick();
        check("basic_d3", aso_data, 3);
        check("basic_e3", aso_error, 0);
        check("basic_level", level, 0);
        tick();
        check("basic_drain", aso_valid, 0);
        check("basic_unf", underflow, 1);
        clr_flags = 1; tick(); clr_flags = 0;
        check("basic_clr", underflow, 0);

        // Backpressure until full, one dropped write
        enable = 0; tick();
        rx.delete();
        enable = 1; aso_ready = 0; wr_en = 1;
        for (int i = 0; i < 18; i++) begin
            wr_data = DW'(100 + i);
            tick();
        end
        wr_en = 0;
        check("bp_valid", aso_valid, 1);
        check("bp_data", aso_data, 100);
        check("bp_level", level, 16);
        check("bp_full", wr_full, 1);
        check("bp_ovf", wr_overflow, 1);
        clr_flags = 1; tick(); clr_flags = 0;
        check("bp_ovf_clr", wr_overflow, 0);

        // Full FIFO with a write on the same edge as a pop
        aso_ready = 1; wr_en = 1; wr_data = 200; tick();
        wr_en = 0;
        check("fp_level", level, 16);
        check("fp_ovf", wr_overflow, 0);
        check("fp_full", wr_full, 1);
        check("fp_data", aso_data, 101);
        repeat (20) tick();
        check("bp_rx_size", rx.size(), 18);
        bad = 0;
        for (int i = 0; i < 18 && i < rx.size(); i++) begin
            if (rx[i] !== ((i < 17) ? DW'(100 + i) : DW'(200))) bad++;
        end
        check("bp_rx_order_bad", bad, 0);

        // Starvation gap
        enable = 0; clr_flags = 1; tick();
        clr_flags = 0; enable = 1; wr_en = 1; wr_data = 10; tick();
        wr_en = 0; tick();
        check("st_d10", aso_data, 10);
        check("st_e10", aso_error, 0);
        tick(); tick(); tick();
        check("st_gap", aso_valid, 0);
        check("st_unf", underflow, 1);
        wr_en = 1; wr_data = 20; tick();
        wr_data = 21; tick();
        wr_en = 0;
        check("st_d20", aso_data, 20);
        check("st_e20", aso_error, 1);
        tick();
        check("st_d21", aso_data, 21);
        check("st_e21", aso_error, 0);
        tick();
        clr_flags = 1; tick(); clr_flags = 0;
        check("st_clr", underflow, 0);

        // ENABLE drop with a pending beat
        enable = 0; tick();
        enable = 1; aso_ready = 0; wr_en = 1; wr_data = 30; tick();
        wr_data = 31; tick();
        wr_data = 32; tick();
        wr_en = 0; enable = 0; tick();
        check("en_hold_v", aso_valid, 1);
        check("en_hold_d", aso_data, 30);
        check("en_level", level, 2);
        aso_ready = 1; tick();
        check("en_off_v", aso_valid, 0);
        check("en_off_level", level, 2);
        tick();
        check("en_off_v2", aso_valid, 0);
        enable = 1; tick();
        check("en_on_v", aso_valid, 1);
        check("en_on_d", aso_data, 31);
        check("en_on_e", aso_error, 0);

        // Asynchronous reset mid-stream
        #2 reset = 1'b1;
        #1;
        check("ar_valid", aso_valid, 0);
        check("ar_data", aso_data, 0);
        check("ar_error", aso_error, 0);
        check("ar_level", level, 0);
        check("ar_full", wr_full, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
